// File: rtl/r_router_1xn_if.sv
`default_nettype none
// ============================================================================
//  Module   : r_router_1xn_if
//  Purpose  : Ingress, egress and statistics signals of the 1-to-N router.
//             The slave modport faces the router; the master modport faces
//             the packet source and the downstream readers.
//  Revision : 1.0 - initial release
// ============================================================================
interface r_router_1xn_if #(
    parameter int DW        = 8,
    parameter int NUM_PORTS = 4,
    parameter int CNT_W     = 16
);
    logic [DW-1:0]           data_in;
    logic                    pkt_valid;
    logic                    busy;
    logic [NUM_PORTS-1:0]    read_enb;
    logic [NUM_PORTS*DW-1:0] data_out;
    logic [NUM_PORTS-1:0]    vld_out;
    logic                    err;
    logic [CNT_W-1:0]        err_cnt;
    logic [CNT_W-1:0]        drop_cnt;

    modport slave (
        input  data_in, pkt_valid, read_enb,
        output busy, data_out, vld_out, err, err_cnt, drop_cnt
    );

    modport master (
        output data_in, pkt_valid, read_enb,
        input  busy, data_out, vld_out, err, err_cnt, drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/r_router_1xn.sv
`default_nettype none
// ============================================================================
//  Module   : r_router_1xn
//  Purpose  : Byte-serial 1-to-N packet router. One ingress FSM routes each
//             packet into a per-port FIFO, checks length and parity, drops
//             unroutable packets and flushes ports whose reader stalls.
//  Revision : 1.0 - initial release
// ============================================================================
module r_router_1xn #(
    parameter int DW         = 8,
    parameter int NUM_PORTS  = 4,
    parameter int AW         = $clog2(NUM_PORTS),
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 30,
    parameter int CNT_W      = 16
) (
    input  logic          clk,
    input  logic          resetn,   // synchronous, active-high despite the name
    r_router_1xn_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = DW - AW;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [AW:0]   PORT_LIMIT = (AW + 1)'(NUM_PORTS);
    localparam logic [PW:0]   DEPTH_CNT  = (PW + 1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DROP = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Ingress FSM state and its next-state values
    // ------------------------------------------------------------------
    state_t           state, state_nxt;
    logic [AW-1:0]    dest, dest_nxt;
    logic [DW-1:0]    parity_acc, parity_nxt;
    logic [LW-1:0]    remaining, remaining_nxt;
    logic             len_err_seen, len_err_nxt;

    logic             busy_c;
    logic             wr_en;
    logic [AW-1:0]    wr_port;
    logic             err_set;
    logic             drop_set;

    logic             err_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] drop_cnt_q;

    // Per-port status gathered from the FIFO generate block
    logic [NUM_PORTS-1:0]    full;
    logic [NUM_PORTS-1:0]    flush;
    logic [NUM_PORTS-1:0]    vld_vec;
    logic [NUM_PORTS*DW-1:0] dout_vec;

    logic [AW-1:0] hdr_addr;
    logic [LW-1:0] hdr_len;
    logic          hdr_bad;

    assign hdr_addr = bus.data_in[AW-1:0];
    assign hdr_len  = bus.data_in[DW-1:AW];
    assign hdr_bad  = ({1'b0, hdr_addr} >= PORT_LIMIT);

    // Next-state, write strobe, busy and error decisions of the ingress FSM
    always_comb begin
        state_nxt     = state;
        dest_nxt      = dest;
        parity_nxt    = parity_acc;
        remaining_nxt = remaining;
        len_err_nxt   = len_err_seen;
        busy_c        = 1'b0;
        wr_en         = 1'b0;
        wr_port       = dest;
        err_set       = 1'b0;
        drop_set      = 1'b0;

        case (state)
            IDLE: begin
                if (bus.pkt_valid) begin
                    if (hdr_bad) begin
                        state_nxt = DROP;
                        drop_set  = 1'b1;
                    end else if (full[hdr_addr]) begin
                        // Hold the header until the destination has room
                        busy_c = 1'b1;
                    end else begin
                        wr_en         = 1'b1;
                        wr_port       = hdr_addr;
                        dest_nxt      = hdr_addr;
                        parity_nxt    = bus.data_in;
                        remaining_nxt = hdr_len;
                        len_err_nxt   = 1'b0;
                        // A flush on the same edge swallows the header, so
                        // the rest of the packet has nowhere to go.
                        state_nxt     = flush[hdr_addr] ? DROP : LOAD;
                    end
                end
            end

            LOAD: begin
                busy_c = full[dest];
                if (!full[dest]) begin
                    wr_en = 1'b1;
                    if (bus.pkt_valid) begin
                        parity_nxt = parity_acc ^ bus.data_in;
                        if (remaining == '0) begin
                            // Over-length: flag it once, keep storing
                            if (!len_err_seen) begin
                                err_set     = 1'b1;
                                len_err_nxt = 1'b1;
                            end
                        end else begin
                            remaining_nxt = remaining - LW'(1);
                        end
                    end else begin
                        state_nxt = IDLE;
                        if (!len_err_seen &&
                            ((parity_acc != bus.data_in) || (remaining != '0))) begin
                            err_set = 1'b1;
                        end
                    end
                end
                // Reader timed out on the port being loaded: abandon the
                // packet silently. If this edge took the parity byte the
                // packet is already over, otherwise discard what remains.
                if (flush[dest]) begin
                    err_set = 1'b0;
                    if (full[dest] || bus.pkt_valid) begin
                        state_nxt = DROP;
                    end
                end
            end

            DROP: begin
                if (!bus.pkt_valid) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM state register and packet tracking registers
    always_ff @(posedge clk) begin
        if (resetn) begin
            state        <= IDLE;
            dest         <= '0;
            parity_acc   <= '0;
            remaining    <= '0;
            len_err_seen <= 1'b0;
        end else begin
            state        <= state_nxt;
            dest         <= dest_nxt;
            parity_acc   <= parity_nxt;
            remaining    <= remaining_nxt;
            len_err_seen <= len_err_nxt;
        end
    end

    // Error pulse and saturating statistics counters
    always_ff @(posedge clk) begin
        if (resetn) begin
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            err_q <= err_set;
            if (err_set && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
            if (drop_set && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Egress FIFOs with per-port read timeout
    // ------------------------------------------------------------------
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [DW-1:0] mem [FIFO_DEPTH];
        logic [PW-1:0] wr_ptr;
        logic [PW-1:0] rd_ptr;
        logic [PW:0]   cnt;
        logic [TW-1:0] timer;
        logic [DW-1:0] dout;
        logic          push;
        logic          pop;
        logic          stall;

        assign push     = wr_en && (wr_port == AW'(p)) && !flush[p];
        assign pop      = bus.read_enb[p] && (cnt != '0);
        assign stall    = (cnt != '0) && !bus.read_enb[p];
        assign flush[p] = stall && (timer == TIMER_LAST);
        assign full[p]  = (cnt == DEPTH_CNT);
        assign vld_vec[p]             = (cnt != '0);
        assign dout_vec[p*DW +: DW]   = dout;

        // Storage array; contents need no reset since count gates reads
        always_ff @(posedge clk) begin
            if (push) begin
                mem[wr_ptr] <= bus.data_in;
            end
        end

        // Pointers, occupancy, stall timer and the output data register
        always_ff @(posedge clk) begin
            if (resetn) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
                timer  <= '0;
                dout   <= '0;
            end else if (flush[p]) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
                timer  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                    dout   <= mem[rd_ptr];
                end
                case ({push, pop})
                    2'b10:   cnt <= cnt + (PW + 1)'(1);
                    2'b01:   cnt <= cnt - (PW + 1)'(1);
                    default: cnt <= cnt;
                endcase
                timer <= stall ? (timer + TW'(1)) : '0;
            end
        end
    end

    assign bus.busy     = busy_c;
    assign bus.vld_out  = vld_vec;
    assign bus.data_out = dout_vec;
    assign bus.err      = err_q;
    assign bus.err_cnt  = err_cnt_q;
    assign bus.drop_cnt = drop_cnt_q;

endmodule
`default_nettype wire

// File: doc/r_router_1xn.md
Name: r_router_1xn

Overview:
- Parametrised 1-to-N packet router: one byte-serial ingress, NUM_PORTS egress FIFOs, one ingress FSM with length tracking and parity check.
- New over the fixed 1x4 router:
  - configurable data width, port count and FIFO depth
  - explicit drop path for unroutable addresses
  - packet-length checking
  - saturating error and drop counters
  - flush of the port being loaded when its read-timeout fires
- Sits between the ingress packet source and the N downstream readers.

Parameters:
- DW, 8: data byte width.
- NUM_PORTS, 4: egress port count, range 2..16.
- AW, $clog2(NUM_PORTS): address field width in the header.
- FIFO_DEPTH, 16: words per egress FIFO, power of 2.
- TIMEOUT, 30: consecutive unread cycles before an egress FIFO is flushed.
- CNT_W, 16: statistics counter width.

Ports:
- clk, input, 1: the only clock. All logic updates on its rising edge.
- resetn, input, 1: reset is synchronous and active-high (1 = reset).
- data_in, input, DW: ingress byte.
- pkt_valid, input, 1: high for header and payload bytes; low on the parity byte.
- busy, output, 1: ingress stall. The source holds data_in/pkt_valid while busy=1.
- read_enb, input, NUM_PORTS: per-port pop request.
- data_out, output, NUM_PORTS*DW: port p occupies bits [p*DW +: DW].
- vld_out, output, NUM_PORTS: port FIFO non-empty.
- err, output, 1: one-cycle pulse on parity or length error.
- err_cnt, output, CNT_W: saturating count of err pulses.
- drop_cnt, output, CNT_W: saturating count of dropped packets.

Behaviour:
- Reset: all outputs 0, FIFOs empty, timers 0, FSM in IDLE. Applies even mid-packet; a partially loaded packet is discarded.
- Packet format:
  - header: [AW-1:0] = addr, [DW-1:AW] = len (0 allowed)
  - then len payload bytes
  - then parity byte = XOR of header and all payload bytes
- A byte is accepted on any edge with pkt_valid=1 and busy=0. The parity byte is accepted with pkt_valid=0 and busy=0 while in LOAD or DROP.
- FSM states:
  - IDLE (busy=0 unless stalled):
    - pkt_valid=1 and addr>=NUM_PORTS: consume header, go to DROP, increment drop_cnt.
    - pkt_valid=1, addr valid, dest FIFO not full: write header, parity_acc=header, remaining=len, go to LOAD.
    - addr valid but dest FIFO full: busy=1 and stay in IDLE; the header is held.
  - LOAD:
    - busy = dest FIFO full.
    - Accepted pkt_valid=1 byte: write it, parity_acc ^= byte, remaining--.
    - Accepted pkt_valid=0 byte: write it, go to IDLE.
    - Error when parity_acc != byte or remaining != 0: err=1 on the next cycle, increment err_cnt. The packet is still stored.
    - pkt_valid=1 while remaining==0: length error. Pulse err once for this packet, count it, keep storing until the parity byte.
  - DROP:
    - busy=0; consume bytes without writing.
    - On the pkt_valid=0 byte, go to IDLE. No err.
- busy is combinational from FSM state, data_in address (IDLE only) and registered FIFO full flags.
- FIFO, per port:
  - Count-based full/empty; vld_out = (count != 0), registered.
  - A byte written at edge t gives vld_out=1 in cycle t+1.
  - Pop: read_enb[p] && !empty loads data_out on that edge. data_out holds otherwise; popping an empty FIFO is ignored.
  - Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap modulo FIFO_DEPTH.
- Timeout, per port:
  - Timer increments while vld_out[p]=1 and read_enb[p]=0. It clears on any read_enb[p]=1 or when empty.
  - After TIMEOUT consecutive such cycles, the FIFO is flushed on that edge: pointers and count go to 0, timer to 0. vld_out[p]=0 next cycle.
  - If the flushed port is the one in LOAD, the FSM goes to DROP and the remainder is discarded, with no err and no drop_cnt.
  - A flush overrides a same-edge write.
- Counters saturate at all-ones.

Test Plan:
- Route: reset, send 0x0E (len 3, port 2), 0x11, 0x22, 0x33, parity 0x0E.
  -> vld_out=4'b0100 from the cycle after the header.
  -> 5 pops return 0x0E, 0x11, 0x22, 0x33, 0x0E.
  -> err=0, err_cnt=0.
- Parity error: same packet with parity 0xFF.
  -> err=1 for exactly 1 cycle after the parity edge; err_cnt=1.
  -> 5 bytes still stored.
- Drop: NUM_PORTS=3, header 0x07 (addr 3, len 1), 0xAA, parity 0xAD.
  -> no vld_out bit rises; drop_cnt=1; busy=0 throughout.
- Backpressure: 20-byte packet to port 0 (header 0x48 = len 18, addr 0), no reads.
  -> busy=1 after the 16th write; source holds.
  -> hold 10 cycles, then pulse read_enb[0]: busy=0 next cycle and the rest is accepted in order.
- Timeout:
  -> complete packet to port 1, no reads: vld_out[1] falls exactly TIMEOUT=30 cycles after it rose.
  -> repeat with read_enb[1]=1 at stall cycle 29: no flush; timer restarts.
- Mid-packet reset: resetn=1 after 2 payload bytes of a packet to port 3.
  -> all vld_out=0, busy=0, counters 0.
  -> the next complete packet routes normally.
